// File: rtl/audio_pkg.sv
// Shared audio constants and sample type for the player and the I2S serializer.
package audio_pkg;

    localparam int FRAME_MCLKS = 256;
    localparam int BCLK_DIV    = 4;
    localparam int SLOT_BITS   = 32;

    typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Player/codec-facing bundle of the I2S serializer.
interface i2s_tx_serializer_if #(
    parameter int SAMPLE_BITS   = 16,
    parameter int UNDERRUN_BITS = 16
);
    logic [7:0]               m_sample_index;
    logic [SAMPLE_BITS-1:0]   l_sample;
    logic [SAMPLE_BITS-1:0]   r_sample;
    logic                     valid;
    logic                     mute;
    logic                     frame_strobe;
    logic [UNDERRUN_BITS-1:0] underrun_cnt;
    logic                     bclk;
    logic                     lrclk;
    logic                     sdata;

    modport master (
        input  l_sample, r_sample, valid, mute,
        output m_sample_index, frame_strobe, underrun_cnt,
        output bclk, lrclk, sdata
    );

    modport slave (
        output l_sample, r_sample, valid, mute,
        input  m_sample_index, frame_strobe, underrun_cnt,
        input  bclk, lrclk, sdata
    );
endinterface

// File: rtl/i2s_bit_select.sv
// Picks the serial bit for a 32-bit I2S slot, with the one-BCLK delay
// and zero padding beyond SAMPLE_BITS.
module i2s_bit_select #(
    parameter int SAMPLE_BITS = 16
) (
    input  logic [5:0]             i_slot,
    input  logic [SAMPLE_BITS-1:0] i_shadow_l,
    input  logic [SAMPLE_BITS-1:0] i_shadow_r,
    output logic                   o_bit
);
    localparam logic [5:0] W_LIM = 6'(SAMPLE_BITS);

    logic [5:0]             w_t;
    logic [SAMPLE_BITS-1:0] w_word;
    logic [SAMPLE_BITS-1:0] w_shift;

    always_comb begin
        w_t     = i_slot - 6'd1;
        w_word  = w_t[5] ? i_shadow_r : i_shadow_l;
        w_shift = w_word << w_t[4:0];
        o_bit   = 1'b0;
        if ({1'b0, w_t[4:0]} < W_LIM)
            o_bit = w_shift[SAMPLE_BITS-1];
    end
endmodule

// File: rtl/i2s_tx_serializer.sv
// Frame counter, sample capture and registered I2S outputs.
module i2s_tx_serializer
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS   = 16,
    parameter int UNDERRUN_BITS = 16
) (
    input  logic                 mclk,
    input  logic                 rst,
    i2s_tx_serializer_if.master  bus
);
    localparam logic [7:0] LAST_IDX = 8'(FRAME_MCLKS - 1);

    logic [7:0]               r_idx;
    logic [SAMPLE_BITS-1:0]   r_shadow_l;
    logic [SAMPLE_BITS-1:0]   r_shadow_r;
    logic [UNDERRUN_BITS-1:0] r_underrun;
    logic                     r_strobe;
    logic                     r_bclk;
    logic                     r_lrclk;
    logic                     r_sdata;

    logic [7:0] w_idx_nxt;
    logic       w_cap;
    logic       w_bit;

    assign w_idx_nxt = r_idx + 8'd1;
    assign w_cap     = (r_idx == LAST_IDX);

    // Old shadows are used here: slot 0 still belongs to the previous frame.
    i2s_bit_select #(.SAMPLE_BITS(SAMPLE_BITS)) u_bit_select (
        .i_slot     (w_idx_nxt[7:2]),
        .i_shadow_l (r_shadow_l),
        .i_shadow_r (r_shadow_r),
        .o_bit      (w_bit)
    );

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_idx      <= '0;
            r_shadow_l <= '0;
            r_shadow_r <= '0;
            r_underrun <= '0;
            r_strobe   <= 1'b0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
        end else begin
            r_idx    <= w_idx_nxt;
            r_strobe <= (w_idx_nxt == LAST_IDX);
            r_bclk   <= w_idx_nxt[1];
            r_lrclk  <= w_idx_nxt[7];
            r_sdata  <= w_bit;
            if (w_cap) begin
                if (bus.mute) begin
                    r_shadow_l <= '0;
                    r_shadow_r <= '0;
                end else if (bus.valid) begin
                    r_shadow_l <= bus.l_sample;
                    r_shadow_r <= bus.r_sample;
                end else begin
                    r_shadow_l <= '0;
                    r_shadow_r <= '0;
                    if (r_underrun != '1)
                        r_underrun <= r_underrun + 1'b1;
                end
            end
        end
    end

    assign bus.m_sample_index = r_idx;
    assign bus.frame_strobe   = r_strobe;
    assign bus.underrun_cnt   = r_underrun;
    assign bus.bclk           = r_bclk;
    assign bus.lrclk          = r_lrclk;
    assign bus.sdata          = r_sdata;
endmodule
